// File: rtl/csi_capture_pkg.sv
// Shared definitions for the CSI frame-capture block.
//   cap_state_e      : capture FSM states
//   ERR_*            : bit positions inside the sticky err vector
//   rgb565_to_rgb332 : colour-depth reduction used on every buffer write
//   *_DEF            : default geometry (VGA) and buffer address width
package csi_capture_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int ADDR_W_DEF   = 18;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } cap_state_e;

  localparam int ERR_WORD_OVF = 0;  // word beyond the end of a line
  localparam int ERR_LINE_OVF = 1;  // word on a line beyond the frame
  localparam int ERR_RESTART  = 2;  // frame_start seen mid-capture

  // Keep the top bits of each colour channel: R[15:13], G[10:8], B[4:3].
  function automatic logic [7:0] rgb565_to_rgb332(input logic [15:0] p);
    return {p[15:13], p[10:8], p[4:3]};
  endfunction

endpackage

// File: rtl/csi_frame_capture_if.sv
// Pixel-stream and frame-buffer write bundle around csi_frame_capture.
//   master : camera decoder / unpacker side (drives sync + pixels, sees writes)
//   slave  : capture block (receives sync + pixels, drives buffer writes)
// Signals:
//   frame_start/frame_end/line_start/line_end : single-cycle sync pulses
//   pix_valid, pix_data[31:0]                 : two RGB565 pixels per word
//   wr_en, wr_addr[ADDR_W-1:0], wr_data[15:0] : one buffer word per strobe
interface csi_frame_capture_if
  import csi_capture_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              frame_start;
  logic              frame_end;
  logic              line_start;
  logic              line_end;
  logic              pix_valid;
  logic [31:0]       pix_data;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;

  modport master (
    output frame_start, frame_end, line_start, line_end, pix_valid, pix_data,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  frame_start, frame_end, line_start, line_end, pix_valid, pix_data,
    output wr_en, wr_addr, wr_data
  );

endinterface

// File: rtl/capture_addr_gen.sv
// Word/line position tracking and buffer address generation for one frame.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   clear        : restart position at word 0 of line 0
//   en           : capture active; all other inputs ignored when low
//   pix_valid    : a pixel word is offered this cycle
//   line_start   : rewind x to the start of the current line
//   line_end     : advance to the next line (only if the line holds words)
//   accept       : offered word is to be written this cycle
//   wr_addr      : buffer address for the accepted word
//   ovf_word     : offered word dropped, line already full
//   ovf_line     : offered word dropped, frame already full
module capture_addr_gen
  import csi_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              en,
  input  logic              pix_valid,
  input  logic              line_start,
  input  logic              line_end,
  output logic              accept,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              ovf_word,
  output logic              ovf_line
);

  localparam int WPL = H_ACTIVE / 2;
  localparam int X_W = $clog2(WPL + 1);
  localparam int Y_W = $clog2(V_ACTIVE + 1);

  localparam logic [X_W-1:0]    X_MAX     = X_W'(WPL);
  localparam logic [Y_W-1:0]    Y_MAX     = Y_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(WPL);

  logic [X_W-1:0]    x_q, x_eff;
  logic [Y_W-1:0]    y_q;
  logic [ADDR_W-1:0] addr_q, base_q;  // base_q tracks y*WPL without a multiplier
  logic              x_full, y_full, line_adv;

  // NOTE: every signal written here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    // A line_start in the same cycle as a word places that word at x=0.
    x_eff    = line_start ? '0 : x_q;
    wr_addr  = line_start ? base_q : addr_q;
    x_full   = (x_eff == X_MAX);
    y_full   = (y_q == Y_MAX);        // y saturates, so == is >=
    accept   = en && !clear && pix_valid && !x_full && !y_full;
    ovf_line = en && !clear && pix_valid && y_full;
    ovf_word = en && !clear && pix_valid && !y_full && x_full;
    // A word accepted together with line_end counts towards the line.
    line_adv = en && !clear && line_end && ((x_eff != '0) || accept);
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      x_q    <= '0;
      y_q    <= '0;
      addr_q <= '0;
      base_q <= '0;
    end else if (line_adv) begin
      x_q <= '0;
      if (!y_full) begin
        y_q    <= y_q + Y_W'(1);
        base_q <= base_q + LINE_STEP;
        addr_q <= base_q + LINE_STEP;
      end
    end else if (accept) begin
      x_q    <= x_eff + X_W'(1);
      addr_q <= wr_addr + ADDR_W'(1);
    end else if (en && line_start) begin
      x_q    <= '0;
      addr_q <= base_q;
    end
  end

endmodule

// File: rtl/csi_frame_capture.sv
// Single-shot frame capture between the RGB565 unpacker and the frame buffer.
// An arm request waits for the next frame_start, then every accepted word is
// reduced to two RGB332 bytes and written one cycle later as a 16-bit word.
// Ports:
//   clk, rst     : pixel clock, synchronous active-high reset
//   arm          : single-cycle capture request (honoured only when idle)
//   bus          : slave side of csi_frame_capture_if (sync, pixels, writes)
//   busy         : capture armed or in progress
//   done         : single-cycle pulse when a capture completes
//   frame_count  : completed captures, wraps at 16 bits
//   err          : sticky {restart, line overflow, word overflow}
module csi_frame_capture
  import csi_capture_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int ADDR_W   = ADDR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      arm,
  csi_frame_capture_if.slave        bus,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               frame_count,
  output logic [2:0]                err
);

  cap_state_e        state, state_nxt;
  logic              cap_en, cnt_clear, restart, arm_take;
  logic              accept, ovf_word, ovf_line;
  logic [ADDR_W-1:0] addr_cur;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (arm)             state_nxt = ARMED;
      ARMED:   if (bus.frame_start) state_nxt = CAPTURE;
      CAPTURE: if (bus.frame_end)   state_nxt = DONE;
      DONE:                         state_nxt = IDLE;
      default:                      state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    cap_en    = 1'b0;
    cnt_clear = 1'b0;
    restart   = 1'b0;
    arm_take  = 1'b0;
    unique case (state)
      IDLE:    arm_take = arm;
      ARMED: begin
        busy      = 1'b1;
        cnt_clear = bus.frame_start;
      end
      CAPTURE: begin
        busy      = 1'b1;
        cap_en    = 1'b1;
        cnt_clear = bus.frame_start;  // partial frame is overwritten from 0
        restart   = bus.frame_start;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  capture_addr_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .ADDR_W   (ADDR_W)
  ) u_addr_gen (
    .clk        (clk),
    .rst        (rst),
    .clear      (cnt_clear),
    .en         (cap_en),
    .pix_valid  (bus.pix_valid),
    .line_start (bus.line_start),
    .line_end   (bus.line_end),
    .accept     (accept),
    .wr_addr    (addr_cur),
    .ovf_word   (ovf_word),
    .ovf_line   (ovf_line)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wr_en   <= 1'b0;
      bus.wr_addr <= '0;
      bus.wr_data <= '0;
      frame_count <= '0;
      err         <= '0;
    end else begin
      bus.wr_en <= accept;
      if (accept) begin
        bus.wr_addr <= addr_cur;
        bus.wr_data <= {rgb565_to_rgb332(bus.pix_data[31:16]),
                        rgb565_to_rgb332(bus.pix_data[15:0])};
      end
      if (state == DONE) frame_count <= frame_count + 16'd1;
      if (arm_take) begin
        err <= '0;
      end else begin
        if (ovf_word) err[ERR_WORD_OVF] <= 1'b1;
        if (ovf_line) err[ERR_LINE_OVF] <= 1'b1;
        if (restart)  err[ERR_RESTART]  <= 1'b1;
      end
    end
  end

endmodule
